rvm_mem_port: RTL and testbench
===============================

Name: rvm_mem_port

Overview:
- Memory bus port for the multi-cycle RISC-V core. Sits directly downstream of the control FSM.
- Accepts one load/store command at a time from the FSM's state-decoded outputs and runs a req/gnt + rvalid bus transaction.
- Returns a one-cycle done pulse, an aligned and extended load result, and an error flag.
- Handles byte-lane steering, misalignment detection and bus-error reporting, so the FSM only waits on ctrl_done.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in ISSUE+WAIT before a forced error. Used only with RVM_MEM_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- ctrl_req  input  1  level; transaction request, sampled only in IDLE
- ctrl_wen  input  1  1 = store, 0 = load
- ctrl_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- ctrl_sext  input  1  sign-extend load result
- ctrl_addr  input  32  byte address
- ctrl_wdata  input  32  store data, right-justified
- ctrl_done  output  1  one-cycle completion pulse
- ctrl_err  output  1  valid with ctrl_done; misaligned, illegal size, bus error or timeout
- ctrl_rdata  output  32  formatted load data, held until next load completes
- busy  output  1  high in any state other than IDLE
- mem_req  output  1  bus request
- mem_gnt  input  1  bus accepts request
- mem_wen  output  1  bus write
- mem_addr  output  32  word address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_strb  output  4  byte enables
- mem_rvalid  input  1  response valid
- mem_rdata  input  32  response data
- mem_berr  input  1  bus error, qualified by mem_rvalid

Behaviour:
Clock and reset (already decided):
- One clock, clk. Reset is asynchronous and active-high, port reset.
- Reset forces state IDLE and all outputs and registers to 0, including ctrl_rdata.
- Reset mid-transaction abandons the transaction; mem_req falls asynchronously.
- A response arriving after reset is ignored.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE: when ctrl_req=1, capture wen/size/sext/addr/wdata into registers.
  - Illegal size or misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1; no bus activity.
  - Otherwise -> ISSUE.
- ISSUE: mem_req=1. mem_wen/mem_addr/mem_wdata/mem_strb are driven from the captured registers and stay stable until the cycle mem_gnt=1, then -> WAIT. mem_rvalid is ignored in ISSUE.
- WAIT: mem_req=0. On mem_rvalid -> RESP. Capture err=mem_berr. For loads with berr=0, capture formatted rdata.
- RESP: ctrl_done=1 and ctrl_err=err for exactly one cycle, then -> IDLE. ctrl_req is ignored in RESP.
- Back-to-back: a request held high in the cycle after RESP is accepted as a new transaction.

Latency (request seen in IDLE at cycle T):
- Misaligned or illegal: done at T+1.
- Minimum bus path (gnt at T+1, rvalid at T+2): done at T+3.
- Each gnt or rvalid stall adds one cycle.

Lane rules (a = addr[1:0]):
- Byte: wdata = {4{wdata[7:0]}}, strb = 0001<<a.
- Half: wdata = {2{wdata[15:0]}}, strb = 0011<<a.
- Word: wdata unchanged, strb = 1111.
- Loads drive the same strb with mem_wen=0.
- Load format: shift mem_rdata right by 8*a, keep 8/16/32 bits, then sign- or zero-extend per sext.
- ctrl_rdata is unchanged by stores and by errored loads.

Optional Feature:
- Macro: RVM_MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - At count == TIMEOUT_CYCLES-1 without completion: -> RESP with err=1, mem_req dropped.
  - A late mem_rvalid is ignored.
- Undefined: the block waits indefinitely, no counter logic exists, and TIMEOUT_CYCLES is unused.

Test Plan:
1. Store byte, addr 0x103, wdata 0x000000A5, gnt/rvalid immediate -> mem_addr 0x100, mem_strb 1000, mem_wdata 0xA5A5A5A5, done at T+3 with err=0.
2. Load half, sext=1, addr 0x202, rdata 0x80011234 -> ctrl_rdata 0xFFFF8001. Same with sext=0 -> 0x00008001.
3. Load word at addr 0x6 -> done at T+1 with err=1; mem_req never asserted; ctrl_rdata unchanged.
4. mem_gnt held low 5 cycles -> mem_req/addr/wdata/strb stable throughout; done 5 cycles later than the minimum.
5. rvalid with berr=1 on a load -> done with err=1, ctrl_rdata unchanged. With RVM_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rvalid -> done with err=1 after 8 cycles in ISSUE/WAIT.
6. reset pulsed while in WAIT -> all outputs 0 immediately; a later rvalid is ignored; the next request completes normally.

Source files
------------

// File: rtl/rvm_mem_port_if.sv
// Memory bus bundle between rvm_mem_port (master) and the memory/interconnect (slave).
// Request phase is req/gnt; the response phase is a single rvalid beat carrying rdata and berr.
interface rvm_mem_port_if;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        rvalid;
    logic [31:0] rdata;
    logic        berr;

    modport master (
        output req, wen, addr, wdata, strb,
        input  gnt, rvalid, rdata, berr
    );

    modport slave (
        input  req, wen, addr, wdata, strb,
        output gnt, rvalid, rdata, berr
    );
endinterface

// File: rtl/rvm_mem_port.sv
// Load/store bus port for the multi-cycle RISC-V core: lane steering, misalignment checks, bus errors.
// Optional watchdog on the bus transaction is enabled with `define RVM_MEM_TIMEOUT_EN.
module rvm_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_req,
    input  logic        ctrl_wen,
    input  logic [1:0]  ctrl_size,
    input  logic        ctrl_sext,
    input  logic [31:0] ctrl_addr,
    input  logic [31:0] ctrl_wdata,
    output logic        ctrl_done,
    output logic        ctrl_err,
    output logic [31:0] ctrl_rdata,
    output logic        busy,
    rvm_mem_port_if.master mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } MemState;

    MemState     state;
    MemState     nextState;

    logic        wenQ;
    logic [1:0]  sizeQ;
    logic        sextQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [3:0]  strbQ;
    logic        errQ;
    logic [31:0] rdataQ;

    logic        cmdBad;
    logic [31:0] laneWdata;
    logic [3:0]  laneStrb;
    logic [31:0] shiftedRdata;
    logic [31:0] loadData;
    logic        timeoutHit;

    // Command checks and store-lane steering work on the raw request so the bus
    // registers hold final values from the first ISSUE cycle onward.
    always_comb begin
        cmdBad    = 1'b0;
        laneWdata = ctrl_wdata;
        laneStrb  = 4'b1111;
        case (ctrl_size)
            2'b00: begin
                laneWdata = {4{ctrl_wdata[7:0]}};
                laneStrb  = 4'b0001 << ctrl_addr[1:0];
            end
            2'b01: begin
                cmdBad    = ctrl_addr[0];
                laneWdata = {2{ctrl_wdata[15:0]}};
                laneStrb  = 4'b0011 << ctrl_addr[1:0];
            end
            2'b10: begin
                cmdBad    = (ctrl_addr[1:0] != 2'b00);
            end
            default: begin
                cmdBad    = 1'b1;
            end
        endcase
    end

    always_comb begin
        shiftedRdata = mem.rdata >> {addrQ[1:0], 3'b000};
        loadData     = shiftedRdata;
        case (sizeQ)
            2'b00:   loadData = {{24{sextQ & shiftedRdata[7]}}, shiftedRdata[7:0]};
            2'b01:   loadData = {{16{sextQ & shiftedRdata[15]}}, shiftedRdata[15:0]};
            default: loadData = shiftedRdata;
        endcase
    end

`ifdef RVM_MEM_TIMEOUT_EN
    localparam int CntWidth = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CntWidth-1:0] timeoutCnt;

    // A response in the same cycle as the last allowed count still wins over the watchdog.
    assign timeoutHit = ((state == ISSUE) || (state == WAIT)) &&
                        (timeoutCnt == CntWidth'(TIMEOUT_CYCLES - 1)) &&
                        !((state == WAIT) && mem.rvalid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeoutCnt <= '0;
        end else if ((state == IDLE) && ctrl_req && !cmdBad) begin
            timeoutCnt <= '0;
        end else if ((state == ISSUE) || (state == WAIT)) begin
            timeoutCnt <= timeoutCnt + 1'b1;
        end
    end
`else
    logic unusedTimeoutParam;

    assign timeoutHit         = 1'b0;
    assign unusedTimeoutParam = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (ctrl_req) begin
                    nextState = cmdBad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (timeoutHit) begin
                    nextState = RESP;
                end else if (mem.gnt) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (mem.rvalid || timeoutHit) begin
                    nextState = RESP;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Command capture and response bookkeeping; ctrl_rdata only moves on a clean load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wenQ   <= 1'b0;
            sizeQ  <= 2'b00;
            sextQ  <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            strbQ  <= '0;
            errQ   <= 1'b0;
            rdataQ <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_req) begin
                        wenQ   <= ctrl_wen;
                        sizeQ  <= ctrl_size;
                        sextQ  <= ctrl_sext;
                        addrQ  <= ctrl_addr;
                        wdataQ <= laneWdata;
                        strbQ  <= laneStrb;
                        errQ   <= cmdBad;
                    end
                end
                ISSUE: begin
                    if (timeoutHit) begin
                        errQ <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem.rvalid) begin
                        errQ <= mem.berr;
                        if (!wenQ && !mem.berr) begin
                            rdataQ <= loadData;
                        end
                    end else if (timeoutHit) begin
                        errQ <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign ctrl_done  = (state == RESP);
    assign ctrl_err   = (state == RESP) && errQ;
    assign ctrl_rdata = rdataQ;

    assign mem.req   = (state == ISSUE);
    assign mem.wen   = wenQ;
    assign mem.addr  = {addrQ[31:2], 2'b00};
    assign mem.wdata = wdataQ;
    assign mem.strb  = strbQ;

endmodule

// File: tb/tb_rvm_mem_port.sv
// Directed self-checking bench for rvm_mem_port; timeout scenario runs when RVM_MEM_TIMEOUT_EN is defined.
module tb_rvm_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_req;
    logic        ctrl_wen;
    logic [1:0]  ctrl_size;
    logic        ctrl_sext;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_done;
    logic        ctrl_err;
    logic [31:0] ctrl_rdata;
    logic        busy;

    rvm_mem_port_if memBus();

`ifdef RVM_MEM_TIMEOUT_EN
    rvm_mem_port #(.TIMEOUT_CYCLES(8)) dut (
`else
    rvm_mem_port dut (
`endif
        .clk        (clk),
        .reset      (reset),
        .ctrl_req   (ctrl_req),
        .ctrl_wen   (ctrl_wen),
        .ctrl_size  (ctrl_size),
        .ctrl_sext  (ctrl_sext),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_done  (ctrl_done),
        .ctrl_err   (ctrl_err),
        .ctrl_rdata (ctrl_rdata),
        .busy       (busy),
        .mem        (memBus)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    int          txCycles;
    logic [31:0] txAddr;
    logic [31:0] txWdata;
    logic [3:0]  txStrb;
    logic        txWen;
    bit          txReqSeen;
    bit          txStable;
    bit          txDone;
    logic        txErr;

    task automatic idleTick();
        ctrl_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drives one command and plays the bus slave; returns with the DUT sitting in RESP.
    task automatic runTxn(input logic wen, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gntStall, input int rvStall,
                          input logic [31:0] rdata, input logic berr, input bit respond);
        int gCnt;
        int rCnt;
        bit granted;
        ctrl_wen      = wen;
        ctrl_size     = size;
        ctrl_sext     = sext;
        ctrl_addr     = addr;
        ctrl_wdata    = wdata;
        ctrl_req      = 1'b1;
        memBus.gnt    = 1'b0;
        memBus.rvalid = 1'b0;
        memBus.rdata  = rdata;
        memBus.berr   = berr;
        txCycles  = 0;
        txReqSeen = 0;
        txStable  = 1;
        txDone    = 0;
        txErr     = 1'b0;
        gCnt      = 0;
        rCnt      = 0;
        granted   = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            txCycles++;
            ctrl_req = 1'b0;
            if (ctrl_done) begin
                txDone = 1;
                txErr  = ctrl_err;
                break;
            end
            if (memBus.req) begin
                if (!txReqSeen) begin
                    txAddr  = memBus.addr;
                    txWdata = memBus.wdata;
                    txStrb  = memBus.strb;
                    txWen   = memBus.wen;
                end else if (txAddr !== memBus.addr || txWdata !== memBus.wdata ||
                             txStrb !== memBus.strb || txWen !== memBus.wen) begin
                    txStable = 0;
                end
                txReqSeen     = 1;
                memBus.gnt    = (gCnt == gntStall);
                if (gCnt == gntStall) granted = 1;
                gCnt++;
                memBus.rvalid = 1'b0;
            end else begin
                memBus.gnt    = 1'b0;
                memBus.rvalid = respond && granted && (rCnt == rvStall);
                if (granted) rCnt++;
            end
        end
        memBus.gnt    = 1'b0;
        memBus.rvalid = 1'b0;
        testsRun++;
        if (!txDone) begin
            testsFailed++;
            $display("[TB] FAIL txn_done_timeout: no ctrl_done after %0d cycles, required done", txCycles);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        ctrl_req      = 1'b0;
        ctrl_wen      = 1'b0;
        ctrl_size     = 2'b00;
        ctrl_sext     = 1'b0;
        ctrl_addr     = '0;
        ctrl_wdata    = '0;
        memBus.gnt    = 1'b0;
        memBus.rvalid = 1'b0;
        memBus.rdata  = '0;
        memBus.berr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if ({ctrl_done, ctrl_err, busy} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: done/err/busy=%b required 000", {ctrl_done, ctrl_err, busy});
        end
        testsRun++;
        if (ctrl_rdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_rdata: got %h required 00000000", ctrl_rdata);
        end
        testsRun++;
        if ({memBus.req, memBus.wen, memBus.strb, memBus.addr, memBus.wdata} !== 71'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_bus: req=%b wen=%b strb=%b addr=%h wdata=%h required all 0",
                     memBus.req, memBus.wen, memBus.strb, memBus.addr, memBus.wdata);
        end
        reset = 1'b0;
        idleTick();
    endtask

    task automatic test_store_byte();
        runTxn(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0, 1'b0, 1);
        testsRun++;
        if (txAddr !== 32'h0000_0100 || txStrb !== 4'b1000 || txWen !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sb_bus: addr=%h strb=%b wen=%b required 00000100 1000 1", txAddr, txStrb, txWen);
        end
        testsRun++;
        if (txWdata !== 32'hA5A5_A5A5) begin
            testsFailed++;
            $display("[TB] FAIL sb_wdata: got %h required a5a5a5a5", txWdata);
        end
        testsRun++;
        if (txCycles != 3 || txErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sb_latency: cycles=%0d err=%b required 3 0", txCycles, txErr);
        end
        testsRun++;
        if (ctrl_rdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL sb_rdata_hold: got %h required 00000000", ctrl_rdata);
        end
        idleTick();
    endtask

    task automatic test_load_half();
        runTxn(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 0, 0, 32'h8001_1234, 1'b0, 1);
        testsRun++;
        if (ctrl_rdata !== 32'hFFFF_8001 || txErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lh_sext: rdata=%h err=%b required ffff8001 0", ctrl_rdata, txErr);
        end
        testsRun++;
        if (txAddr !== 32'h0000_0200 || txStrb !== 4'b1100 || txWen !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lh_bus: addr=%h strb=%b wen=%b required 00000200 1100 0", txAddr, txStrb, txWen);
        end
        idleTick();
        runTxn(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 0, 0, 32'h8001_1234, 1'b0, 1);
        testsRun++;
        if (ctrl_rdata !== 32'h0000_8001) begin
            testsFailed++;
            $display("[TB] FAIL lh_zext: got %h required 00008001", ctrl_rdata);
        end
        idleTick();
    endtask

    task automatic test_lanes();
        runTxn(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_BEEF, 0, 0, 32'h0, 1'b0, 1);
        testsRun++;
        if (txWdata !== 32'hBEEF_BEEF || txStrb !== 4'b1100 || txAddr !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL sh_lanes: wdata=%h strb=%b addr=%h required beefbeef 1100 00000000",
                     txWdata, txStrb, txAddr);
        end
        idleTick();
        runTxn(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0, 1);
        testsRun++;
        if (txWdata !== 32'hDEAD_BEEF || txStrb !== 4'b1111 || txAddr !== 32'h10) begin
            testsFailed++;
            $display("[TB] FAIL sw_lanes: wdata=%h strb=%b addr=%h required deadbeef 1111 00000010",
                     txWdata, txStrb, txAddr);
        end
        idleTick();
        runTxn(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 0, 0, 32'h0000_F200, 1'b0, 1);
        testsRun++;
        if (ctrl_rdata !== 32'hFFFF_FFF2 || txStrb !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL lb_sext: rdata=%h strb=%b required fffffff2 0010", ctrl_rdata, txStrb);
        end
        idleTick();
        runTxn(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 1);
        testsRun++;
        if (ctrl_rdata !== 32'h1234_5678) begin
            testsFailed++;
            $display("[TB] FAIL lw_data: got %h required 12345678", ctrl_rdata);
        end
        idleTick();
        runTxn(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 0, 0, 32'h9A00_0000, 1'b0, 1);
        testsRun++;
        if (ctrl_rdata !== 32'h0000_009A || txStrb !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL lbu_top: rdata=%h strb=%b required 0000009a 1000", ctrl_rdata, txStrb);
        end
        idleTick();
    endtask

    task automatic test_misaligned();
        runTxn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 32'h5555_5555, 1'b0, 1);
        testsRun++;
        if (txCycles != 1 || txErr !== 1'b1 || txReqSeen) begin
            testsFailed++;
            $display("[TB] FAIL lw_misaligned: cycles=%0d err=%b reqSeen=%0d required 1 1 0",
                     txCycles, txErr, txReqSeen);
        end
        testsRun++;
        if (ctrl_rdata !== 32'h0000_009A) begin
            testsFailed++;
            $display("[TB] FAIL misaligned_rdata_hold: got %h required 0000009a", ctrl_rdata);
        end
        idleTick();
        runTxn(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'h0, 1'b0, 1);
        testsRun++;
        if (txCycles != 1 || txErr !== 1'b1 || txReqSeen) begin
            testsFailed++;
            $display("[TB] FAIL illegal_size: cycles=%0d err=%b reqSeen=%0d required 1 1 0",
                     txCycles, txErr, txReqSeen);
        end
        idleTick();
        runTxn(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 0, 0, 32'h0, 1'b0, 1);
        testsRun++;
        if (txCycles != 1 || txErr !== 1'b1 || txReqSeen) begin
            testsFailed++;
            $display("[TB] FAIL lh_misaligned: cycles=%0d err=%b reqSeen=%0d required 1 1 0",
                     txCycles, txErr, txReqSeen);
        end
        idleTick();
    endtask

    task automatic test_stalls();
        runTxn(1'b1, 2'b10, 1'b0, 32'h0000_0044, 32'h1122_3344, 5, 0, 32'h0, 1'b0, 1);
        testsRun++;
        if (txCycles != 8 || !txStable || txErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL gnt_stall: cycles=%0d stable=%0d err=%b required 8 1 0",
                     txCycles, txStable, txErr);
        end
        testsRun++;
        if (txAddr !== 32'h44 || txWdata !== 32'h1122_3344 || txStrb !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL gnt_stall_bus: addr=%h wdata=%h strb=%b required 00000044 11223344 1111",
                     txAddr, txWdata, txStrb);
        end
        idleTick();
        runTxn(1'b0, 2'b10, 1'b0, 32'h0000_0048, 32'h0, 0, 2, 32'h5566_7788, 1'b0, 1);
        testsRun++;
        if (txCycles != 5 || ctrl_rdata !== 32'h5566_7788) begin
            testsFailed++;
            $display("[TB] FAIL rvalid_stall: cycles=%0d rdata=%h required 5 55667788", txCycles, ctrl_rdata);
        end
        idleTick();
    endtask

    task automatic test_bus_error();
        runTxn(1'b0, 2'b10, 1'b0, 32'h0000_0050, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b1, 1);
        testsRun++;
        if (txCycles != 3 || txErr !== 1'b1 || ctrl_rdata !== 32'h5566_7788) begin
            testsFailed++;
            $display("[TB] FAIL bus_error: cycles=%0d err=%b rdata=%h required 3 1 55667788",
                     txCycles, txErr, ctrl_rdata);
        end
        idleTick();
        testsRun++;
        if (ctrl_err !== 1'b0 || ctrl_done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_pulse: done=%b err=%b after RESP required 0 0", ctrl_done, ctrl_err);
        end
    endtask

    task automatic test_back_to_back();
        runTxn(1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'h0, 0, 0, 32'h7F00_0000, 1'b0, 1);
        testsRun++;
        if (ctrl_rdata !== 32'h0000_007F || txCycles != 3) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: rdata=%h cycles=%0d required 0000007f 3", ctrl_rdata, txCycles);
        end
        ctrl_wen  = 1'b0;
        ctrl_size = 2'b10;
        ctrl_addr = 32'h0000_0002;
        ctrl_req  = 1'b1;
        @(posedge clk);
        #1;
        testsRun++;
        if (ctrl_done !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_idle: done=%b busy=%b required 0 0", ctrl_done, busy);
        end
        @(posedge clk);
        #1;
        ctrl_req = 1'b0;
        testsRun++;
        if (ctrl_done !== 1'b1 || ctrl_err !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: done=%b err=%b required 1 1", ctrl_done, ctrl_err);
        end
        idleTick();
    endtask

`ifdef RVM_MEM_TIMEOUT_EN
    task automatic test_timeout();
        runTxn(1'b0, 2'b10, 1'b0, 32'h0000_0060, 32'h0, 0, 0, 32'h0, 1'b0, 0);
        testsRun++;
        if (txCycles != 9 || txErr !== 1'b1 || ctrl_rdata !== 32'h0000_007F) begin
            testsFailed++;
            $display("[TB] FAIL timeout: cycles=%0d err=%b rdata=%h required 9 1 0000007f",
                     txCycles, txErr, ctrl_rdata);
        end
        idleTick();
    endtask
`endif

    task automatic test_reset_mid();
        ctrl_wen   = 1'b0;
        ctrl_size  = 2'b10;
        ctrl_sext  = 1'b0;
        ctrl_addr  = 32'h0000_0030;
        ctrl_req   = 1'b1;
        memBus.gnt = 1'b1;
        @(posedge clk);
        #1;
        ctrl_req = 1'b0;
        @(posedge clk);
        #1;
        memBus.gnt = 1'b0;
        testsRun++;
        if (busy !== 1'b1 || memBus.req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_wait_state: busy=%b req=%b required 1 0", busy, memBus.req);
        end
        #1;
        reset = 1'b1;
        #1;
        testsRun++;
        if (busy !== 1'b0 || memBus.addr !== 32'h0 || ctrl_rdata !== 32'h0 || memBus.strb !== 4'h0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: busy=%b addr=%h rdata=%h strb=%b required 0 00000000 00000000 0000",
                     busy, memBus.addr, ctrl_rdata, memBus.strb);
        end
        #1;
        reset         = 1'b0;
        memBus.rvalid = 1'b1;
        memBus.rdata  = 32'hCAFE_F00D;
        memBus.berr   = 1'b0;
        @(posedge clk);
        #1;
        memBus.rvalid = 1'b0;
        testsRun++;
        if (ctrl_done !== 1'b0 || busy !== 1'b0 || ctrl_rdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL late_rvalid: done=%b busy=%b rdata=%h required 0 0 00000000",
                     ctrl_done, busy, ctrl_rdata);
        end
        runTxn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 1);
        testsRun++;
        if (txCycles != 3 || txErr !== 1'b0 || ctrl_rdata !== 32'h0BAD_F00D) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_txn: cycles=%0d err=%b rdata=%h required 3 0 0badf00d",
                     txCycles, txErr, ctrl_rdata);
        end
        idleTick();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_lanes();
        test_misaligned();
        test_stalls();
        test_bus_error();
        test_back_to_back();
`ifdef RVM_MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
